// File: rtl/cmd_fetcher.sv
// cmd_fetcher: pops header+payload words from a FIFO and presents assembled commands (CMD_FETCH_STATS_EN adds an issue counter)
module cmd_fetcher #(
  parameter int MAX_PAY = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  output logic                   o_rd_en,
  input  logic [31:0]            i_rd_data,
  input  logic                   i_empty,
  output logic                   o_cmd_valid,
  input  logic                   i_cmd_ready,
  output logic [7:0]             o_cmd_op,
  output logic [7:0]             o_cmd_id,
  output logic [2:0]             o_cmd_len,
  output logic [32*MAX_PAY-1:0]  o_cmd_payload,
  output logic                   o_err_len,
  output logic [15:0]            o_cmd_count,
  output logic                   o_busy
);
  typedef enum logic [2:0] {IDLE, HDR, PAY, ISSUE, DROP} state_t;
  localparam logic [2:0] MAX_LEN = 3'(MAX_PAY);
  state_t state, state_nx;
  logic inflight;
  logic [2:0] idx;
  logic last;
  logic want;
  logic unused_hdr_bits;
  assign unused_hdr_bits = ^i_rd_data[15:3];
  assign last = (idx + 3'd1) == o_cmd_len;
  assign want = !inflight && !i_empty && (idx < o_cmd_len);
  assign o_cmd_valid = state == ISSUE;
  assign o_busy = state != IDLE;
  // state register
  always_ff @(posedge i_clk)
    state <= !i_reset_n ? IDLE : state_nx;
  // next state and pop request; data returns the cycle after a pop, so inflight is simply last cycle's pop
  always_comb begin
    state_nx = state;
    o_rd_en = 1'b0;
    case (state)
      IDLE: begin
        o_rd_en = !i_empty;
        state_nx = i_empty ? IDLE : HDR;
      end
      HDR: state_nx = i_rd_data[2:0] == 3'd0 ? ISSUE : i_rd_data[2:0] > MAX_LEN ? DROP : PAY;
      PAY: begin
        o_rd_en = want;
        state_nx = inflight && last ? ISSUE : PAY;
      end
      ISSUE: state_nx = i_cmd_ready ? IDLE : ISSUE;
      DROP: begin
        o_rd_en = want;
        state_nx = inflight && last ? IDLE : DROP;
      end
      default: state_nx = IDLE;
    endcase
    if (!i_reset_n) o_rd_en = 1'b0;
  end
  // header capture, payload assembly and sticky length error
  always_ff @(posedge i_clk)
    if (!i_reset_n) begin
      inflight <= 1'b0;
      idx <= '0;
      o_cmd_op <= '0;
      o_cmd_id <= '0;
      o_cmd_len <= '0;
      o_cmd_payload <= '0;
      o_err_len <= 1'b0;
    end else begin
      inflight <= o_rd_en;
      if (state == HDR) begin
        o_cmd_op <= i_rd_data[31:24];
        o_cmd_id <= i_rd_data[23:16];
        o_cmd_len <= i_rd_data[2:0];
        o_cmd_payload <= '0;
        idx <= '0;
        if (i_rd_data[2:0] > MAX_LEN) o_err_len <= 1'b1;
      end
      if (inflight && (state == PAY || state == DROP)) idx <= idx + 3'd1;
      if (inflight && state == PAY)
        for (int k = 0; k < MAX_PAY; k++)
          if (idx == 3'(k)) o_cmd_payload[32*k +: 32] <= i_rd_data;
    end
`ifdef CMD_FETCH_STATS_EN
  // issued-command counter, wraps naturally at 16 bits
  always_ff @(posedge i_clk)
    o_cmd_count <= !i_reset_n ? 16'd0 : o_cmd_count + 16'(o_cmd_valid && i_cmd_ready);
`else
  assign o_cmd_count = 16'd0;
`endif
endmodule

// File: tb/tb_cmd_fetcher.sv
// tb_cmd_fetcher: directed bench with a FIFO model and a command-stream reference model
module tb_cmd_fetcher;
  localparam int MP = 4;
`ifdef CMD_FETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  typedef struct packed {
    logic [7:0] op;
    logic [7:0] id;
    logic [2:0] len;
    logic [32*MP-1:0] pay;
  } cmd_t;
  logic clk = 1'b0, reset_n = 1'b0, empty = 1'b1, cmd_ready = 1'b1;
  logic rd_en, cmd_valid, err_len, busy;
  logic [31:0] rd_data = '0;
  logic [7:0] op, id;
  logic [2:0] len;
  logic [32*MP-1:0] payload;
  logic [15:0] cmd_count;
  int tests = 0, fails = 0, cyc = 0, pops = 0, mcount = 0, first_rd = -1, first_valid = -1;
  logic [31:0] fq[$];
  cmd_t exp_q[$];
  cmd_t cur;
  int need = 0, drop = 0;
  logic exp_err = 1'b0;
  logic held = 1'b0;
  logic [146:0] snap;

  cmd_fetcher #(.MAX_PAY(MP)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .o_rd_en(rd_en), .i_rd_data(rd_data), .i_empty(empty),
    .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready), .o_cmd_op(op), .o_cmd_id(id), .o_cmd_len(len),
    .o_cmd_payload(payload), .o_err_len(err_len), .o_cmd_count(cmd_count), .o_busy(busy)
  );

  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // FIFO model: one-cycle read latency, flag refreshed after the edge
  always @(posedge clk) begin
    cyc++;
    if (rd_en && !empty) begin
      rd_data <= fq.pop_front();
      pops++;
    end
    #3 empty = (fq.size() == 0);
  end

  // word stream parser: headers, payload collection, oversize drops
  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    if (drop > 0) drop--;
    else if (need > 0) begin
      cur.pay[32*(int'(cur.len) - need) +: 32] = w;
      need--;
      if (need == 0) exp_q.push_back(cur);
    end else begin
      cur = '{op: w[31:24], id: w[23:16], len: w[2:0], pay: '0};
      if (w[2:0] == 3'd0) exp_q.push_back(cur);
      else if (int'(w[2:0]) > MP) begin
        drop = int'(w[2:0]);
        exp_err = 1'b1;
      end else need = int'(w[2:0]);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (!reset_n) held = 1'b0;
    else begin
      if (rd_en) chk("rd_guard", 160'({empty, cmd_valid}), 160'(0));
      chk("count", 160'(cmd_count), 160'(STATS ? 16'(mcount) : 16'd0));
      if (held) chk("stable", 160'({cmd_valid, op, id, len, payload}), 160'({1'b1, snap}));
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_cmd got=%0h want=none", {op, id, len, payload});
        end else chk("cmd", 160'({op, id, len, payload}), 160'(exp_q.pop_front()));
        mcount++;
      end
      held = cmd_valid && !cmd_ready;
      snap = {op, id, len, payload};
      if (rd_en && first_rd < 0) first_rd = cyc;
      if (cmd_valid && first_valid < 0) first_valid = cyc;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_valid();
    int t = 0;
    while (!cmd_valid && t < 300) begin tick(); t++; end
    chk("timeout_valid", 160'(cmd_valid), 160'(1));
  endtask
  task automatic wait_idle();
    int t = 0;
    tick(4);
    while ((busy || !empty) && t < 300) begin tick(); t++; end
    chk("timeout_idle", 160'({busy, empty}), 160'(1));
  endtask
  task automatic wait_mc(input int n);
    int t = 0;
    while (mcount < n && t < 300) begin tick(); t++; end
    chk("timeout_count", 160'(mcount), 160'(n));
  endtask

  initial begin
    int p0, mc0;
    tick(3);
    chk("reset_outs", 160'({rd_en, cmd_valid, op, id, len, payload, err_len, cmd_count, busy}), 160'(0));
    reset_n = 1'b1;
    tick(2);
    // single command with latency
    first_rd = -1;
    first_valid = -1;
    push(32'h12340002); push(32'hAAAA0001); push(32'hBBBB0002);
    wait_valid();
    chk("t1_fields", 160'({op, id, len}), 160'({8'h12, 8'h34, 3'd2}));
    chk("t1_payload", 160'(payload), 160'({32'h0, 32'h0, 32'hBBBB0002, 32'hAAAA0001}));
    tick();
    chk("t1_latency", 160'(first_valid - first_rd), 160'(6));
    wait_idle();
    // zero length
    p0 = pops;
    push(32'h05070000);
    wait_valid();
    chk("t2_fields", 160'({op, id, len, payload}), 160'({8'h05, 8'h07, 3'd0, 128'h0}));
    wait_idle();
    chk("t2_pops", 160'(pops - p0), 160'(1));
    // back-pressure
    cmd_ready = 1'b0;
    mc0 = mcount;
    push(32'h21000001); push(32'h11111111);
    push(32'h22010002); push(32'h22222222); push(32'h33333333);
    wait_valid();
    p0 = pops;
    tick(10);
    chk("t3_valid_held", 160'({cmd_valid, op}), 160'({1'b1, 8'h21}));
    chk("t3_no_pops", 160'(pops - p0), 160'(0));
    cmd_ready = 1'b1;
    wait_mc(mc0 + 2);
    wait_idle();
    // starvation mid-payload
    push(32'h31020003); push(32'hC0000001);
    tick(20);
    chk("t4_stalled", 160'({busy, cmd_valid, rd_en}), 160'(3'b100));
    push(32'hC0000002);
    tick();
    push(32'hC0000003);
    wait_valid();
    chk("t4_payload", 160'(payload), 160'({32'h0, 32'hC0000003, 32'hC0000002, 32'hC0000001}));
    wait_idle();
    // illegal length then a legal command
    chk("t5_err_before", 160'(err_len), 160'(0));
    p0 = pops;
    push(32'h01020007);
    for (int i = 0; i < 7; i++) push(32'hDEAD0000 + 32'(i));
    push(32'h41030001); push(32'hDDDDDDDD);
    wait_valid();
    chk("t5_err", 160'(err_len), 160'(exp_err));
    chk("t5_fields", 160'({op, id, len, payload}), 160'({8'h41, 8'h03, 3'd1, 96'h0, 32'hDDDDDDDD}));
    wait_idle();
    chk("t5_pops", 160'(pops - p0), 160'(10));
    chk("t5_err_sticky", 160'(err_len), 160'(1));
    // reset mid-payload, then three commands
    push(32'h51000003); push(32'h5A5A5A5A);
    tick(8);
    chk("t6_in_pay", 160'({busy, cmd_valid}), 160'(2'b10));
    reset_n = 1'b0;
    exp_q.delete();
    need = 0;
    drop = 0;
    exp_err = 1'b0;
    mcount = 0;
    tick(2);
    chk("t6_reset_outs", 160'({rd_en, cmd_valid, op, id, len, payload, err_len, cmd_count, busy}), 160'(0));
    reset_n = 1'b1;
    push(32'h61000001); push(32'h66666666);
    push(32'h62010000);
    push(32'h63020002); push(32'h77777777); push(32'h88888888);
    wait_mc(3);
    wait_idle();
    chk("t6_count", 160'(cmd_count), 160'(STATS ? 16'd3 : 16'd0));
    chk("t6_err", 160'(err_len), 160'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cmd_fetcher.md
CMD_FETCHER -- requirements
Module: cmd_fetcher

Interface
REQ-001 SHALL have parameter MAX_PAY, default 4, meaning the maximum payload words per command (legal header lengths are 0..MAX_PAY).
REQ-002 SHALL have port i_clk, input, 1, the clock.
REQ-003 SHALL have port i_reset_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port o_rd_en, output, 1, the FIFO pop request.
REQ-005 SHALL have port i_rd_data, input, 32, FIFO read data, valid one cycle after an accepted pop.
REQ-006 SHALL have port i_empty, input, 1, the FIFO empty flag.
REQ-007 SHALL have port o_cmd_valid, output, 1, meaning an assembled command is presented.
REQ-008 SHALL have port i_cmd_ready, input, 1, the downstream accept.
REQ-009 SHALL have port o_cmd_op, output, 8, the opcode (header[31:24]).
REQ-010 SHALL have port o_cmd_id, output, 8, the command id (header[23:16]).
REQ-011 SHALL have port o_cmd_len, output, 3, the payload word count (header[2:0]).
REQ-012 SHALL have port o_cmd_payload, output, 32*MAX_PAY, the payload; word k sits at bits [32k+31:32k].
REQ-013 SHALL have port o_err_len, output, 1, a sticky flag set by an illegal length.
REQ-014 SHALL have port o_cmd_count, output, 16, the number of commands issued.
REQ-015 SHALL have port o_busy, output, 1, high whenever the state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, HDR, PAY, ISSUE and DROP.
REQ-017 SHALL assert o_rd_en only when all three hold: i_empty=0, no pop is in flight, and the state is IDLE, PAY or DROP with words outstanding.
- At most one pop is in flight at a time.
- Each word therefore costs 2 cycles.
REQ-018 SHALL, in IDLE, issue a pop when i_empty=0 and move to HDR.
REQ-019 SHALL, in HDR, capture the header from i_rd_data as follows:
- len=0: go to ISSUE.
- 1 <= len <= MAX_PAY: go to PAY.
- len > MAX_PAY: set o_err_len and go to DROP.
REQ-020 SHALL, in PAY, store returned word n into payload slot n and go to ISSUE on the cycle the last word is captured.
REQ-021 SHALL, in PAY, keep o_rd_en low while i_empty=1 and hold the partial payload indefinitely (no timeout).
REQ-022 SHALL, in DROP, pop and discard exactly len words, then return to IDLE without asserting o_cmd_valid.
REQ-023 SHALL, in ISSUE, hold o_cmd_valid=1 with all command fields stable until the cycle i_cmd_ready=1, then return to IDLE.
REQ-024 SHALL NOT pop from the FIFO while in ISSUE; back-pressure stalls the FIFO read side.
REQ-025 SHALL zero unused payload slots (index >= len) when a command is issued.
REQ-026 SHALL ignore header bits [15:3].
REQ-027 SHALL give a minimum latency of 2+2*len cycles from the first o_rd_en to o_cmd_valid.
REQ-028 SHALL clear o_err_len only by reset.

Reset
REQ-029 SHALL, when i_reset_n=0 at a clock edge, force:
- state to IDLE and clear the in-flight flag;
- o_rd_en=0 and o_cmd_valid=0;
- o_cmd_op, o_cmd_id, o_cmd_len and o_cmd_payload to 0;
- o_err_len=0, o_cmd_count=0 and o_busy=0.
REQ-030 SHALL discard a partially assembled or unaccepted command when reset asserts mid-operation.
- No data from a pop in flight is captured after reset.

Configuration
REQ-031 SHALL, with CMD_FETCH_STATS_EN defined, increment o_cmd_count by 1 on each o_cmd_valid&&i_cmd_ready handshake.
- The counter wraps from 0xFFFF to 0x0000.
- DROP sequences are not counted.
REQ-032 SHALL, with CMD_FETCH_STATS_EN undefined, tie o_cmd_count to 0 and implement no counter logic.

Verification
REQ-033 Single command:
- Stimulus: FIFO holds header 0x12340002, then 0xAAAA0001, 0xBBBB0002; ready=1.
- Required: op=0x12, id=0x34, len=2, payload={0,0,0xBBBB0002,0xAAAA0001}.
- Required: valid asserts 6 cycles after the first o_rd_en.
REQ-034 Zero-length command:
- Stimulus: header 0x05070000.
- Required: valid with len=0, payload all-zero, and only one pop issued.
REQ-035 Back-pressure:
- Stimulus: two queued commands; ready=0 for 10 cycles.
- Required: valid and fields stay stable for 10 cycles with no pops.
- Required: after ready=1, the second command is fetched.
REQ-036 Starvation:
- Stimulus: header len=3; the FIFO empties after payload word 1; word 2 arrives 20 cycles later, then word 3.
- Required: o_rd_en stays low while empty, and the final payload is correct.
REQ-037 Illegal length:
- Stimulus: header 0x01020007, then 7 junk words, then a legal command.
- Required: o_err_len=1, 8 words consumed, no valid for the bad command, and the legal command issues correctly.
REQ-038 Reset mid-PAY and stats:
- Stimulus: reset asserted after 1 of 3 payload words, then 3 legal commands.
- Required: all outputs return to 0.
- Required: o_cmd_count=3 with CMD_FETCH_STATS_EN defined, and 0 without it.
